// File: rtl/complex_accumulator.sv
// Accumulates TAPS complex partial products per output, rounds/saturates the sum
// to the output Q-format and presents it through a 2-entry valid/ready buffer.
module complex_accumulator #(
    parameter int TAPS     = 16,
    parameter int PP_W     = 52,
    parameter int PP_FRAC  = 47,
    parameter int OUT_W    = 32,
    parameter int OUT_FRAC = 28
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             pp_valid,
    input  logic [PP_W-1:0]  pp_i,
    input  logic [PP_W-1:0]  pp_q,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_i,
    output logic [OUT_W-1:0] out_q,
    output logic             out_sat,
    output logic             overrun
);
    localparam int ACC_W = PP_W + $clog2(TAPS);
    localparam int SHIFT = PP_FRAC - OUT_FRAC;
    localparam int CNT_W = $clog2(TAPS);
    localparam int RND_W = ACC_W + 1;
    localparam int ENT_W = 2 * OUT_W + 1;

    logic [CNT_W-1:0]        tapCnt;
    logic                    lastTap;
    logic signed [ACC_W-1:0] accI, accQ;
    logic signed [ACC_W-1:0] ppIExt, ppQExt, sumI, sumQ;
    logic                    sumDone;

    logic                    rndValid;
    logic [OUT_W-1:0]        rndI, rndQ;
    logic                    rndSat;
    logic [OUT_W:0]          rsI, rsQ;

    logic [ENT_W-1:0]        mem [2];
    logic                    wrPtr, rdPtr;
    logic [1:0]              count;
    logic                    full, pop, accept, drop;
    logic [ENT_W-1:0]        head;

    assign ppIExt  = {{(ACC_W-PP_W){pp_i[PP_W-1]}}, pp_i};
    assign ppQExt  = {{(ACC_W-PP_W){pp_q[PP_W-1]}}, pp_q};
    assign lastTap = (tapCnt == CNT_W'(TAPS - 1));
    assign sumI    = (tapCnt == '0) ? ppIExt : accI + ppIExt;
    assign sumQ    = (tapCnt == '0) ? ppQExt : accQ + ppQExt;

    // One extra bit keeps the rounding bias from overflowing a near-full-scale sum.
    // Returns {clipped, value}.
    function automatic logic [OUT_W:0] roundSat(input logic signed [ACC_W-1:0] s);
        logic signed [RND_W-1:0] biased, r, maxV, minV;
        maxV   = (RND_W'(1) <<< (OUT_W - 1)) - RND_W'(1);
        minV   = ~maxV;
        biased = {s[ACC_W-1], s} + (RND_W'(1) <<< (SHIFT - 1));
        r      = biased >>> SHIFT;
        if (r > maxV)      return {1'b1, maxV[OUT_W-1:0]};
        else if (r < minV) return {1'b1, minV[OUT_W-1:0]};
        else               return {1'b0, r[OUT_W-1:0]};
    endfunction

    assign rsI = roundSat(accI);
    assign rsQ = roundSat(accQ);

    // acc still holds the final sum on the cycle after the last tap, even if a new
    // block starts then, so the round stage reads acc directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tapCnt   <= '0;
            accI     <= '0;
            accQ     <= '0;
            sumDone  <= 1'b0;
            rndValid <= 1'b0;
            rndI     <= '0;
            rndQ     <= '0;
            rndSat   <= 1'b0;
        end else if (clr) begin
            tapCnt   <= '0;
            accI     <= '0;
            accQ     <= '0;
            sumDone  <= 1'b0;
            rndValid <= 1'b0;
            rndI     <= '0;
            rndQ     <= '0;
            rndSat   <= 1'b0;
        end else begin
            sumDone  <= pp_valid && lastTap;
            rndValid <= sumDone;
            if (sumDone) begin
                rndI   <= rsI[OUT_W-1:0];
                rndQ   <= rsQ[OUT_W-1:0];
                rndSat <= rsI[OUT_W] | rsQ[OUT_W];
            end
            if (pp_valid) begin
                accI   <= sumI;
                accQ   <= sumQ;
                tapCnt <= lastTap ? '0 : tapCnt + CNT_W'(1);
            end
        end
    end

    // Output handshake: a head entry transfers on any edge where out_valid && out_ready;
    // head data holds while out_valid && !out_ready, and out_valid only falls after a pop.
    assign full   = (count == 2'd2);
    assign pop    = out_valid && out_ready;
    assign accept = rndValid && (!full || pop);
    assign drop   = rndValid && full && !pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0]  <= '0;
            mem[1]  <= '0;
            wrPtr   <= 1'b0;
            rdPtr   <= 1'b0;
            count   <= '0;
            overrun <= 1'b0;
        end else if (clr) begin
            mem[0]  <= '0;
            mem[1]  <= '0;
            wrPtr   <= 1'b0;
            rdPtr   <= 1'b0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            if (accept) begin
                mem[wrPtr] <= {rndI, rndQ, rndSat};
                wrPtr      <= ~wrPtr;
            end
            if (pop) rdPtr <= ~rdPtr;
            count <= count + 2'(accept) - 2'(pop);
            if (drop) overrun <= 1'b1;
        end
    end

    assign head      = mem[rdPtr];
    assign out_valid = (count != 2'd0);
    assign out_i     = head[ENT_W-1 -: OUT_W];
    assign out_q     = head[OUT_W:1];
    assign out_sat   = head[0];
endmodule

// File: tb/tb_complex_accumulator.sv
// Directed checks for complex_accumulator: latency, rounding, saturation,
// backpressure/overrun, gapped input, clr and asynchronous reset.
module tb_complex_accumulator;
    logic        clk = 1'b0;
    logic        rst_n, clr, pp_valid, out_ready;
    logic [51:0] pp_i, pp_q;
    logic        out_valid, out_sat, overrun;
    logic [31:0] out_i, out_q;

    int tests_run    = 0;
    int tests_failed = 0;

    complex_accumulator dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .pp_valid(pp_valid),
        .pp_i(pp_i), .pp_q(pp_q), .out_valid(out_valid), .out_ready(out_ready),
        .out_i(out_i), .out_q(out_q), .out_sat(out_sat), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic drive_pp(input logic [51:0] vi, input logic [51:0] vq);
        pp_valid = 1'b1; pp_i = vi; pp_q = vq;
        @(posedge clk); #1;
        pp_valid = 1'b0;
    endtask

    task automatic send_block(input logic [51:0] i0, input logic [51:0] q0,
                              input logic [51:0] ir, input logic [51:0] qr);
        drive_pp(i0, q0);
        repeat (15) drive_pp(ir, qr);
    endtask

    task automatic get_result(output bit ok, output logic [31:0] oi, output logic [31:0] oq,
                              output logic os);
        ok = 1'b0; oi = '0; oq = '0; os = 1'b0;
        for (int c = 0; c < 10 && !ok; c++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                ok = 1'b1; oi = out_i; oq = out_q; os = out_sat;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clr = 1'b0; pp_valid = 1'b0; out_ready = 1'b1; pp_i = '0; pp_q = '0;
        #3;
        tests_run++;
        if ({out_valid, out_i, out_q, out_sat, overrun} !== 67'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got v=%b i=%h q=%h s=%b o=%b, want all 0",
                     out_valid, out_i, out_q, out_sat, overrun);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_basic();
        send_block(52'd1 << 19, -(52'd1 << 19), 52'd1 << 19, -(52'd1 << 19));
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++; $display("FAIL basic_lat_t0: out_valid=%b want 0", out_valid);
        end
        @(posedge clk); #1;
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++; $display("FAIL basic_lat_t1: out_valid=%b want 0", out_valid);
        end
        @(posedge clk); #1;
        tests_run++;
        if (out_valid !== 1'b1 || out_i !== 32'd16 || out_q !== -32'sd16 || out_sat !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_t2: v=%b i=%0d q=%0d s=%b, want v=1 i=16 q=-16 s=0",
                     out_valid, $signed(out_i), $signed(out_q), out_sat);
        end
        @(posedge clk); #1;
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++; $display("FAIL basic_pop: out_valid=%b want 0 after pop", out_valid);
        end
    endtask

    task automatic test_rounding();
        logic [51:0] v [3];
        logic [31:0] e [3];
        bit ok; logic [31:0] oi, oq; logic os;
        v[0] = 52'd1 << 18;         e[0] = 32'd1;
        v[1] = -(52'd1 << 18);      e[1] = 32'd0;
        v[2] = -(52'd1 << 18) - 1;  e[2] = -32'sd1;
        for (int k = 0; k < 3; k++) begin
            send_block(v[k], '0, '0, '0);
            get_result(ok, oi, oq, os);
            tests_run++;
            if (!ok || oi !== e[k] || oq !== 32'd0 || os !== 1'b0) begin
                tests_failed++;
                $display("FAIL rounding_%0d: ok=%b i=%0d q=%0d s=%b, want i=%0d q=0 s=0",
                         k, ok, $signed(oi), $signed(oq), os, $signed(e[k]));
            end
        end
    endtask

    task automatic test_saturation();
        bit ok; logic [31:0] oi, oq; logic os;
        logic [51:0] pmax, nmin;
        pmax = (52'd1 << 51) - 1;
        nmin = 52'd1 << 51;
        send_block(pmax, nmin, pmax, nmin);
        get_result(ok, oi, oq, os);
        tests_run++;
        if (!ok || oi !== 32'h7FFF_FFFF || oq !== 32'h8000_0000 || os !== 1'b1) begin
            tests_failed++;
            $display("FAIL saturation: ok=%b i=%h q=%h s=%b, want i=7fffffff q=80000000 s=1",
                     ok, oi, oq, os);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int k = 1; k <= 3; k++) send_block(52'(k) << 19, '0, '0, '0);
        repeat (3) begin @(posedge clk); #1; end
        tests_run++;
        if (out_valid !== 1'b1 || out_i !== 32'd1 || overrun !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_held: v=%b i=%0d ovr=%b, want v=1 i=1 ovr=1",
                     out_valid, $signed(out_i), overrun);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (out_valid !== 1'b1 || out_i !== 32'd2) begin
            tests_failed++;
            $display("FAIL bp_second: v=%b i=%0d, want v=1 i=2", out_valid, $signed(out_i));
        end
        @(posedge clk); #1;
        tests_run++;
        if (out_valid !== 1'b0 || overrun !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_drained: v=%b ovr=%b, want v=0 ovr=1", out_valid, overrun);
        end
    endtask

    task automatic test_clr_mid();
        bit ok; logic [31:0] oi, oq; logic os;
        repeat (5) drive_pp(52'd100 << 19, 52'd100 << 19);
        clr = 1'b1; pp_valid = 1'b1; pp_i = 52'd77 << 19; pp_q = 52'd77 << 19;
        @(posedge clk); #1;
        clr = 1'b0; pp_valid = 1'b0;
        tests_run++;
        if (overrun !== 1'b0 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL clr_state: ovr=%b v=%b, want 0 0", overrun, out_valid);
        end
        send_block(52'd1 << 19, 52'd1 << 20, 52'd1 << 19, 52'd1 << 20);
        get_result(ok, oi, oq, os);
        tests_run++;
        if (!ok || oi !== 32'd16 || oq !== 32'd32 || os !== 1'b0) begin
            tests_failed++;
            $display("FAIL clr_fresh: ok=%b i=%0d q=%0d s=%b, want i=16 q=32 s=0",
                     ok, $signed(oi), $signed(oq), os);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_gapped();
        logic [31:0] got_i [4];
        logic [31:0] got_q [4];
        int n = 0;
        fork
            begin
                for (int b = 0; b < 2; b++)
                    for (int k = 1; k <= 16; k++) begin
                        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                        if (b == 0) drive_pp(52'(k) << 19, (52'd1 << 18) + 52'd1);
                        else        drive_pp(-(52'(k) << 19), -(52'd3 << 17));
                    end
            end
            begin
                for (int c = 0; c < 250; c++) begin
                    @(posedge clk); #1;
                    if (out_valid && out_ready && n < 4) begin
                        got_i[n] = out_i; got_q[n] = out_q; n++;
                    end
                end
            end
        join
        tests_run++;
        if (n !== 2) begin
            tests_failed++; $display("FAIL gapped_count: got %0d results, want 2", n);
        end else begin
            tests_run++;
            if (got_i[0] !== 32'd136 || got_q[0] !== 32'd8) begin
                tests_failed++;
                $display("FAIL gapped_r0: i=%0d q=%0d, want i=136 q=8",
                         $signed(got_i[0]), $signed(got_q[0]));
            end
            tests_run++;
            if (got_i[1] !== -32'sd136 || got_q[1] !== -32'sd12) begin
                tests_failed++;
                $display("FAIL gapped_r1: i=%0d q=%0d, want i=-136 q=-12",
                         $signed(got_i[1]), $signed(got_q[1]));
            end
        end
    endtask

    task automatic test_full_push_pop();
        out_ready = 1'b0;
        for (int k = 5; k <= 7; k++) send_block(52'(k) << 19, '0, '0, '0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1 || out_i !== 32'd6 || overrun !== 1'b0) begin
            tests_failed++;
            $display("FAIL fullpp_head: v=%b i=%0d ovr=%b, want v=1 i=6 ovr=0",
                     out_valid, $signed(out_i), overrun);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (out_valid !== 1'b1 || out_i !== 32'd7) begin
            tests_failed++;
            $display("FAIL fullpp_third: v=%b i=%0d, want v=1 i=7", out_valid, $signed(out_i));
        end
        @(posedge clk); #1;
        tests_run++;
        if (out_valid !== 1'b0 || overrun !== 1'b0) begin
            tests_failed++;
            $display("FAIL fullpp_end: v=%b ovr=%b, want 0 0", out_valid, overrun);
        end
    endtask

    task automatic test_rst_mid();
        bit ok; logic [31:0] oi, oq; logic os;
        out_ready = 1'b0;
        send_block(52'd1 << 19, -(52'd1 << 19), 52'd1 << 19, -(52'd1 << 19));
        repeat (7) drive_pp(52'd1 << 19, 52'd1 << 19);
        tests_run++;
        if (out_valid !== 1'b1 || out_i !== 32'd16) begin
            tests_failed++;
            $display("FAIL rst_pre: v=%b i=%0d, want v=1 i=16", out_valid, $signed(out_i));
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({out_valid, out_i, out_q, out_sat, overrun} !== 67'd0) begin
            tests_failed++;
            $display("FAIL rst_async: v=%b i=%h q=%h s=%b o=%b, want all 0",
                     out_valid, out_i, out_q, out_sat, overrun);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        send_block(52'd3 << 19, 52'd2 << 19, '0, '0);
        get_result(ok, oi, oq, os);
        tests_run++;
        if (!ok || oi !== 32'd3 || oq !== 32'd2 || os !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_fresh: ok=%b i=%0d q=%0d s=%b, want i=3 q=2 s=0",
                     ok, $signed(oi), $signed(oq), os);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_saturation();
        test_backpressure();
        test_clr_mid();
        test_gapped();
        test_full_push_pop();
        test_rst_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
